// File: rtl/btn_debounce_500hz.sv
// btn_debounce_500hz: 500 Hz square wave to tick, plus per-button sync and debounce
// Ports:
//   clk_100MHz    in   system clock
//   reset         in   synchronous active-high reset
//   i_sq_500Hz    in   500 Hz square wave from the slow-clock divider
//   i_btn         in   raw asynchronous buttons, active-high
//   o_tick        out  one-cycle pulse per rising edge of i_sq_500Hz
//   o_btn_level   out  debounced button levels
//   o_btn_press   out  one-cycle pulse on debounced 0->1
//   o_btn_release out  one-cycle pulse on debounced 1->0
module btn_debounce_500hz #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 5
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             i_sq_500Hz,
    input  logic [N_BTN-1:0] i_btn,
    output logic             o_tick,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release
);
    localparam int CW = $clog2(STABLE_TICKS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic             sq_cur_q, sq_cur_d;
    logic             sq_prev_q, sq_prev_d;
    logic             tick_q, tick_d;
    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];

    always_comb begin
        // only a definite 1 counts as high, so an unsettled divider never makes a tick
        sq_cur_d  = (i_sq_500Hz === 1'b1);
        sq_prev_d = sq_cur_q;
        tick_d    = sq_cur_q & ~sq_prev_q;
        s1_d      = i_btn;
        s2_d      = s1_q;
        level_d   = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // both wave history flops reset high so a wave already high after reset gives no tick
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sq_cur_q  <= 1'b1;
            sq_prev_q <= 1'b1;
            tick_q    <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sq_cur_q  <= sq_cur_d;
            sq_prev_q <= sq_prev_d;
            tick_q    <= tick_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign o_tick        = tick_q;
    assign o_btn_level   = level_q;
    assign o_btn_press   = press_q;
    assign o_btn_release = release_q;
endmodule

// File: tb/tb_btn_debounce_500hz.sv
// tb_btn_debounce_500hz: checks two debounce builds (5 ticks and 1 tick) against a history-based model
module tb_btn_debounce_500hz;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sq = 1'b1;
    logic [N-1:0] btn = '0;
    logic         tick5, tick1;
    logic [N-1:0] lvl5, pr5, rl5, lvl1, pr1, rl1;
    logic [3*N:0] obs5, obs1, exp5, exp1;

    always #5 clk = ~clk;

    btn_debounce_500hz #(.N_BTN(N), .STABLE_TICKS(5)) u5 (
        .clk_100MHz(clk), .reset(reset), .i_sq_500Hz(sq), .i_btn(btn),
        .o_tick(tick5), .o_btn_level(lvl5), .o_btn_press(pr5), .o_btn_release(rl5)
    );

    btn_debounce_500hz #(.N_BTN(N), .STABLE_TICKS(1)) u1 (
        .clk_100MHz(clk), .reset(reset), .i_sq_500Hz(sq), .i_btn(btn),
        .o_tick(tick1), .o_btn_level(lvl1), .o_btn_press(pr1), .o_btn_release(rl1)
    );

    assign obs5 = {tick5, lvl5, pr5, rl5};
    assign obs1 = {tick1, lvl1, pr1, rl1};

    int tests = 0;
    int fails = 0;

    bit wave_run = 1'b0;
    bit sq_hold  = 1'b1;
    int half     = 10;
    int ph       = 0;

    // model: full input history since reset; a change is accepted on the st-th tick
    // seen while the synchronised input stays different from the accepted level
    logic         wq[$];
    logic [N-1:0] bq[$];
    int           n;
    int           st[2] = '{5, 1};
    logic [N-1:0] m_lvl[2], m_pr[2], m_rl[2];
    int           m_pend[2][N];
    logic         m_tick;

    task automatic model_init();
        wq = '{1'b1, 1'b1, 1'b1};
        bq = '{'0, '0};
        n = 0;
        m_tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = '0;
            m_pr[k] = '0;
            m_rl[k] = '0;
            for (int i = 0; i < N; i++) m_pend[k][i] = 0;
        end
        exp5 = '0;
        exp1 = '0;
    endtask

    task automatic step();
        logic         tu;
        logic [N-1:0] s2u;
        if (wave_run) begin
            sq = (ph >= half);
            ph = (ph + 1) % (2 * half);
        end else begin
            sq = sq_hold;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            model_init();
        end else begin
            n++;
            wq.push_back(sq);
            bq.push_back(btn);
            tu  = wq[n] & ~wq[n-1];
            s2u = bq[n-1];
            for (int k = 0; k < 2; k++) begin
                m_pr[k] = '0;
                m_rl[k] = '0;
                for (int i = 0; i < N; i++) begin
                    if (s2u[i] == m_lvl[k][i]) begin
                        m_pend[k][i] = 0;
                    end else if (tu) begin
                        m_pend[k][i]++;
                        if (m_pend[k][i] == st[k]) begin
                            m_pend[k][i] = 0;
                            m_lvl[k][i] = s2u[i];
                            if (s2u[i]) m_pr[k][i] = 1'b1;
                            else m_rl[k][i] = 1'b1;
                        end
                    end
                end
            end
            m_tick = wq[n+1] & ~wq[n];
            exp5 = {m_tick, m_lvl[0], m_pr[0], m_rl[0]};
            exp1 = {m_tick, m_lvl[1], m_pr[1], m_rl[1]};
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wave_run = 1'b0;
        sq_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (obs5 !== '0 || obs1 !== '0) begin
                fails++;
                $display("FAIL reset cyc %0d: dut5 %h dut1 %h, need 0", c, obs5, obs1);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_tick_idle();
        int bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (tick5 !== 1'b0 || obs5 !== exp5 || obs1 !== exp1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL tick_idle: %0d cycles wrong, need 0", bad);
        end
        sq_hold = 1'b0;
        for (int c = 0; c < 3; c++) step();
        sq_hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            tests++;
            if (tick5 !== (c == 1) || tick1 !== (c == 1)) begin
                fails++;
                $display("FAIL tick_latency cyc %0d: tick5 %b tick1 %b, need %b", c, tick5, tick1, c == 1);
            end
        end
    endtask

    task automatic test_press();
        int np = 0;
        wave_run = 1'b1;
        half = 10;
        ph = 0;
        btn[0] = 1'b1;
        for (int c = 0; c < 140; c++) begin
            step();
            np += int'(pr5[0]);
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL press cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
        tests++;
        if (np != 1 || lvl5[0] !== 1'b1) begin
            fails++;
            $display("FAIL press_count: pulses %0d level %b, need 1 and 1", np, lvl5[0]);
        end
    endtask

    task automatic test_bounce();
        int seen = 0;
        int np = 0;
        btn[1] = 1'b1;
        for (int c = 0; c < 200 && seen < 4; c++) begin
            step();
            seen += int'(tick5);
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL bounce_pre cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
        tests++;
        if (seen < 4 || lvl5[1] !== 1'b0) begin
            fails++;
            $display("FAIL bounce_wait: ticks %0d level %b, need 4 and 0", seen, lvl5[1]);
        end
        btn[1] = 1'b0;
        step();
        btn[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 160; c++) begin
            step();
            np += int'(pr5[1]);
            if (pr5[1] && seen < 5) begin
                tests++;
                fails++;
                $display("FAIL bounce_early: press after %0d ticks, need 5", seen);
            end
            seen += int'(tick5);
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL bounce cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
        tests++;
        if (np != 1 || lvl5[1] !== 1'b1) begin
            fails++;
            $display("FAIL bounce_count: pulses %0d level %b, need 1 and 1", np, lvl5[1]);
        end
    endtask

    task automatic test_release();
        int nr = 0;
        int np = 0;
        btn[0] = 1'b0;
        for (int c = 0; c < 140; c++) begin
            step();
            nr += int'(rl5[0]);
            np += int'(pr5[0]);
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL release cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
        tests++;
        if (nr != 1 || np != 0 || lvl5[0] !== 1'b0) begin
            fails++;
            $display("FAIL release_count: rel %0d press %0d level %b, need 1 0 0", nr, np, lvl5[0]);
        end
    endtask

    task automatic test_simultaneous();
        int c2 = -1;
        int c3 = -1;
        btn[3:2] = 2'b11;
        for (int c = 0; c < 140; c++) begin
            step();
            if (pr5[2]) c2 = c;
            if (pr5[3]) c3 = c;
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL simul cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
        tests++;
        if (c2 < 0 || c2 != c3) begin
            fails++;
            $display("FAIL simul_same: press2 at %0d press3 at %0d, need equal and seen", c2, c3);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int np = 0;
        btn = 4'b0011;
        for (int c = 0; c < 200 && seen < 3; c++) begin
            step();
            seen += int'(tick5);
        end
        tests++;
        if (seen < 3) begin
            fails++;
            $display("FAIL reset_mid_wait: ticks %0d, need 3", seen);
        end
        reset = 1'b1;
        step();
        tests++;
        if (obs5 !== '0 || obs1 !== '0) begin
            fails++;
            $display("FAIL reset_mid: dut5 %h dut1 %h, need 0", obs5, obs1);
        end
        reset = 1'b0;
        for (int c = 0; c < 160; c++) begin
            step();
            np += int'(pr5[0]);
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL reset_mid_after cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
        tests++;
        if (np != 1 || lvl5 !== 4'b0011) begin
            fails++;
            $display("FAIL reset_mid_count: press0 %0d level %b, need 1 and 0011", np, lvl5);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(39) == 0) btn[i] = ~btn[i];
            if (c % 400 == 0) begin
                wave_run = ($urandom_range(3) != 0);
                sq_hold = 1'($urandom_range(1));
            end
            if (wave_run && ph == 0) half = int'($urandom_range(12, 2));
            step();
            tests++;
            if (obs5 !== exp5 || obs1 !== exp1) begin
                fails++;
                $display("FAIL random cyc %0d: dut5 %h need %h, dut1 %h need %h", c, obs5, exp5, obs1, exp1);
            end
        end
    endtask

    task automatic test_tick_freq();
        int t5 = 0;
        int t1 = 0;
        wave_run = 1'b0;
        sq_hold = 1'b0;
        for (int c = 0; c < 4; c++) step();
        wave_run = 1'b1;
        half = 10;
        ph = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            t5 += int'(tick5);
            t1 += int'(tick1);
        end
        tests++;
        if (t5 != 10 || t1 != 10) begin
            fails++;
            $display("FAIL tick_freq: dut5 %0d dut1 %0d pulses, need 10", t5, t1);
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_tick_idle();
        test_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_tick_freq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
